// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared writeback-side widths, bank-switch FSM states and request record
package regfile_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int BANK_W = 6;
    typedef enum logic [1:0] {IDLE, DRAIN, ACK} bank_state_e;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: requester handshake, two register-file write ports and bank control
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int BANK_W = regfile_pkg::BANK_W
);
    logic [NUM_REQ-1:0] reqValid_i;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr_i;
    logic [NUM_REQ*DATA_W-1:0] reqData_i;
    logic [NUM_REQ-1:0] reqReady_o;
    logic portAWriteEnable_o;
    logic portBWriteEnable_o;
    logic [ADDR_W-1:0] portAWriteAddress_o;
    logic [ADDR_W-1:0] portBWriteAddress_o;
    logic [DATA_W-1:0] portAWriteData_o;
    logic [DATA_W-1:0] portBWriteData_o;
    logic bankSwitchReq_i;
    logic [BANK_W-1:0] bankSwitchTarget_i;
    logic [BANK_W-1:0] bankSelect_o;
    logic bankSwitchAck_o;
    modport slave (
        input reqValid_i, reqAddr_i, reqData_i, bankSwitchReq_i, bankSwitchTarget_i,
        output reqReady_o, portAWriteEnable_o, portBWriteEnable_o, portAWriteAddress_o,
        portBWriteAddress_o, portAWriteData_o, portBWriteData_o, bankSelect_o, bankSwitchAck_o
    );
    modport master (
        output reqValid_i, reqAddr_i, reqData_i, bankSwitchReq_i, bankSwitchTarget_i,
        input reqReady_o, portAWriteEnable_o, portBWriteEnable_o, portAWriteAddress_o,
        portBWriteAddress_o, portAWriteData_o, portBWriteData_o, bankSelect_o, bankSwitchAck_o
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rr_pick: first set bit of mask searching cyclically upward from start
module rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    logic [IW:0] j;
    always_comb begin
        found_o = 1'b0;
        idx_o = '0;
        j = '0;
        // descending offsets so the nearest set bit is the last one written
        for (int i = N - 1; i >= 0; i--) begin
            j = {1'b0, start_i} + (IW+1)'(i);
            if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
            if (mask_i[j[IW-1:0]]) begin
                found_o = 1'b1;
                idx_o = j[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin two-port register-file write arbiter with bank-switch sequencing
module regfile_write_arbiter import regfile_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int BANK_W = regfile_pkg::BANK_W
) (
    input logic clock_i,
    input logic reset_i,
    regfile_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    bank_state_e state_q, state_d;
    logic [BANK_W-1:0] bank_q, bank_d, target_q, target_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d, a_idx, b_idx, b_start, b_next;
    logic a_found, b_found, grant_ok, gnt_a, gnt_b;
    logic [NUM_REQ-1:0] addr_match, b_mask;
    logic [ADDR_W-1:0] addr_a, addr_b, addr_a_q, addr_b_q;
    logic [DATA_W-1:0] data_a, data_b, data_a_q, data_b_q;
    logic en_a_q, en_b_q;

    rr_pick #(.N(NUM_REQ)) u_pick_a (
        .mask_i(bus.reqValid_i), .start_i(rr_ptr_q), .found_o(a_found), .idx_o(a_idx)
    );

    rr_pick #(.N(NUM_REQ)) u_pick_b (
        .mask_i(b_mask), .start_i(b_start), .found_o(b_found), .idx_o(b_idx)
    );

    always_comb begin
        addr_a = bus.reqAddr_i[a_idx*ADDR_W +: ADDR_W];
        addr_b = bus.reqAddr_i[b_idx*ADDR_W +: ADDR_W];
        data_a = bus.reqData_i[a_idx*DATA_W +: DATA_W];
        data_b = bus.reqData_i[b_idx*DATA_W +: DATA_W];
        addr_match = '0;
        for (int k = 0; k < NUM_REQ; k++) addr_match[k] = bus.reqAddr_i[k*ADDR_W +: ADDR_W] == addr_a;
        // a same-address partner would race A into the same register, so it waits
        b_mask = bus.reqValid_i & ~(NUM_REQ'(1) << a_idx) & ~addr_match;
        b_start = (a_idx == IW'(NUM_REQ - 1)) ? '0 : a_idx + 1'b1;
        b_next = (b_idx == IW'(NUM_REQ - 1)) ? '0 : b_idx + 1'b1;
        grant_ok = state_q == IDLE && !bus.bankSwitchReq_i && !reset_i;
        gnt_a = grant_ok && a_found;
        gnt_b = gnt_a && b_found;
        bus.reqReady_o = ({NUM_REQ{gnt_a}} & (NUM_REQ'(1) << a_idx)) | ({NUM_REQ{gnt_b}} & (NUM_REQ'(1) << b_idx));
        rr_ptr_d = gnt_b ? b_next : gnt_a ? b_start : rr_ptr_q;
    end

    always_comb begin
        state_d = state_q;
        target_d = target_q;
        bank_d = bank_q;
        case (state_q)
            IDLE: begin
                state_d = bus.bankSwitchReq_i ? DRAIN : IDLE;
                target_d = bus.bankSwitchReq_i ? bus.bankSwitchTarget_i : target_q;
            end
            DRAIN: begin
                state_d = ACK;
                bank_d = target_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            bank_q <= '0;
            target_q <= '0;
            rr_ptr_q <= '0;
            en_a_q <= 1'b0;
            en_b_q <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q <= bank_d;
            target_q <= target_d;
            rr_ptr_q <= rr_ptr_d;
            en_a_q <= gnt_a;
            en_b_q <= gnt_b;
            addr_a_q <= gnt_a ? addr_a : '0;
            addr_b_q <= gnt_b ? addr_b : '0;
            data_a_q <= gnt_a ? data_a : '0;
            data_b_q <= gnt_b ? data_b : '0;
        end
    end

    assign bus.portAWriteEnable_o = en_a_q;
    assign bus.portBWriteEnable_o = en_b_q;
    assign bus.portAWriteAddress_o = addr_a_q;
    assign bus.portBWriteAddress_o = addr_b_q;
    assign bus.portAWriteData_o = data_a_q;
    assign bus.portBWriteData_o = data_b_q;
    assign bus.bankSelect_o = bank_q;
    assign bus.bankSwitchAck_o = state_q == ACK && !reset_i;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's two write ports (A, B) among NUM_REQ writeback requesters (ALU, load/store, assign units) using a valid/ready handshake and round-robin priority. It issues up to two non-conflicting writes per cycle through registered port outputs. It also owns the register file's bank select and sequences bank switches so that no write ever lands in the wrong bank. It sits between the functional-unit writeback stage and the register file write ports.

## Interface
- NUM_REQ, 4: number of write requesters (2..8)
- ADDR_W, 5: register address width
- DATA_W, 16: register data width
- BANK_W, 6: bank select width

- clock_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- reqValid_i  in  NUM_REQ  per-requester write request
- reqAddr_i  in  NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
- reqData_i  in  NUM_REQ*DATA_W  packed data; requester k at [k*DATA_W +: DATA_W]
- reqReady_o  out  NUM_REQ  grant; transfer occurs when valid & ready
- portAWriteEnable_o / portBWriteEnable_o  out  1  write strobe to register file port
- portAWriteAddress_o / portBWriteAddress_o  out  ADDR_W  write address
- portAWriteData_o / portBWriteData_o  out  DATA_W  write data
- bankSwitchReq_i  in  1  request to change bank (level)
- bankSwitchTarget_i  in  BANK_W  new bank; sampled with the request
- bankSelect_o  out  BANK_W  current bank, drives register file bankSelect
- bankSwitchAck_o  out  1  one-cycle pulse: switch complete

## Operation
- Requesters hold valid, addr and data stable until granted. The block never drops a valid request.
- Grant is combinational from the current inputs, state and pointer.
- Port A candidate: the first valid requester, searching cyclically from rrPtr.
- Port B candidate: the next valid requester after A, searching cyclically, whose address differs from A's address. A same-address requester is skipped and waits.
- Grants are issued only in state IDLE with bankSwitchReq_i low.
- rrPtr update on any grant: (index of last granted requester + 1) mod NUM_REQ. With no grant, rrPtr holds.
- Granted requests are registered onto the port outputs. Port A carries the lower-priority-order grant. Enables are 0 when there is no grant.
- Bank switch FSM:
  - IDLE: if bankSwitchReq_i is high, grant nothing, capture bankSwitchTarget_i, go to DRAIN.
  - DRAIN: write enables are 0 this cycle. At the clock edge, load bankSelect_o with the captured target and go to ACK.
  - ACK: bankSwitchAck_o=1, no grants, go to IDLE.
- bankSwitchReq_i still high on return to IDLE starts a new switch. Requesters must drop it on ack.

## Timing
- Reset values: all reqReady_o 0 while reset_i is high; write enables 0; addresses and data 0; bankSelect_o 0; bankSwitchAck_o 0; rrPtr 0; FSM IDLE.
- Reset mid-switch aborts the switch: bank returns to 0 and no ack is issued.
- Latency: a grant in cycle T drives the port outputs in T+1. The register file commits the write at the end of T+1 using bankSelect_o of T+1.
- Bank switch:
  - Request seen in cycle T: no grants in T. Writes granted in T-1 still drive in T under the old bank.
  - T+1 DRAIN: no writes.
  - T+2: bankSelect_o holds the new value, ack is high, no grants.
  - T+3: grants resume.
- Throughput: 2 writes/cycle when two or more valid requesters have distinct addresses.
- A single valid requester gets port A only.
- Pointer wrap: index NUM_REQ-1 granted → rrPtr=0.

## Structure
- Package regfile_pkg: ADDR_W/DATA_W/BANK_W defaults, the FSM state enum (IDLE, DRAIN, ACK), and a request struct {addr, data}. The register file and other writeback-side blocks share this package.
- Sub-module rr_pick: given a NUM_REQ mask and a start index, returns found + index of the first set bit cyclically. Instantiate it twice:
  - A: mask = valid.
  - B: mask = valid & ~onehot(A) & ~addrMatch(A), start = A+1.

## Test plan
- Reset, then requester 0 valid with addr 3, data 0x1234 → ready[0]=1 that cycle. Next cycle portAWriteEnable_o=1, addr 3, data 0x1234, portB enable 0. rrPtr=1.
- All 4 requesters valid with addrs 1,2,3,4 at rrPtr=0 → grants 0 (A) and 1 (B). Next cycle grants 2 and 3. Then 0 and 1 again (wrap).
- Requesters 0 and 1 valid, both addr 7 → only 0 granted (port A). Requester 1 is granted next cycle on port A, rrPtr=2.
- Writes in flight plus bankSwitchReq_i=1 with target 5 in cycle T → ready all 0 for T..T+2. No enables in T+1. bankSelect_o=5 and ack=1 in T+2. The pre-request write commits in bank 0.
- Assert reset_i in DRAIN with target 9 → bankSelect_o=0, ack never pulses, FSM IDLE, grants resume after reset deasserts.
- Random valid/stall with a scoreboard → every request is written exactly once with its own addr/data. No requester waits more than NUM_REQ grant cycles.
